timer_tick_scheduler: RTL and testbench

- Avalon-MM master sequencer that owns the 16-bit register interface of the system interval timer (5,000,000-cycle period, address map 0..5).
- Enables the timer interrupt at init, services each irq, and clears status.
- On each irq, snapshots and reads back the live counter and delivers a tick event with a sequence number and service latency to one consumer through a valid/ready handshake.
- Sits between the timer peripheral and the sketch/accelerometer sampling logic, replacing software ISR handling.

---
 rtl/timer_tick_scheduler.sv | 149 ++++++++++++++
 tb/tb_timer_tick_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master that owns the interval timer's register port: arms the irq,
// services each timeout, snapshots the counter and emits a tick event downstream.
module timer_tick_scheduler #(
    parameter logic [22:0] LOAD_VALUE = 23'h4C4B3F,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic             tick_valid,
    input  logic             tick_ready,
    output logic [CNT_W-1:0] tick_seq,
    output logic [22:0]      tick_latency,
    output logic [CNT_W-1:0] overrun_count,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_OFF,
        S_EN,
        S_IDLE,
        S_DIS,
        S_CLR,
        S_SNAP,
        S_RDL,
        S_RDH,
        S_CAP,
        S_EMIT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [22:0]      r_snap;
    logic             r_tick_valid;
    logic [CNT_W-1:0] r_tick_seq;
    logic [22:0]      r_tick_latency;
    logic [CNT_W-1:0] r_overrun;
    logic [22:0]      w_latency;
    logic             w_unused_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus outputs decode from state alone, so a reset drops them to idle at once.
    always_comb begin
        w_next         = r_state;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = '0;
        tmr_writedata  = '0;
        case (r_state)
            S_OFF: begin
                if (enable) w_next = S_EN;
            end
            S_EN: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0001;
                w_next         = S_IDLE;
            end
            S_IDLE: begin
                if (!enable)      w_next = S_DIS;
                else if (tmr_irq) w_next = S_CLR;
            end
            S_DIS: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                w_next         = S_OFF;
            end
            S_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd0;
                w_next         = S_SNAP;
            end
            S_SNAP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd4;
                w_next         = S_RDL;
            end
            S_RDL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd4;
                w_next         = S_RDH;
            end
            S_RDH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd5;
                w_next         = S_CAP;
            end
            S_CAP:   w_next = S_EMIT;
            S_EMIT:  w_next = S_IDLE;
            default: w_next = S_OFF;
        endcase
    end

    // Readdata lags the address by one cycle: RDH sees the low half, CAP the high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
        end else if (r_state == S_RDH) begin
            r_snap[15:0] <= tmr_readdata;
        end else if (r_state == S_CAP) begin
            r_snap[22:16] <= tmr_readdata[6:0];
        end
    end

    assign w_latency   = LOAD_VALUE - r_snap;
    assign w_unused_rd = &{1'b0, tmr_readdata[15:7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_valid   <= 1'b0;
            r_tick_seq     <= '0;
            r_tick_latency <= '0;
            r_overrun      <= '0;
        end else if (r_state == S_EMIT) begin
            r_tick_valid   <= 1'b1;
            r_tick_seq     <= r_tick_seq + CNT_W'(1);
            r_tick_latency <= w_latency;
            if (r_tick_valid && !tick_ready && !(&r_overrun)) begin
                r_overrun <= r_overrun + CNT_W'(1);
            end
        end else if (r_tick_valid && tick_ready) begin
            r_tick_valid <= 1'b0;
        end
    end

    assign tick_valid    = r_tick_valid;
    assign tick_seq      = r_tick_seq;
    assign tick_latency  = r_tick_latency;
    assign overrun_count = r_overrun;
    assign busy          = (r_state != S_IDLE) && (r_state != S_OFF);

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: behavioural timer peripheral, a table of reset/first-tick
// vectors, directed corner sequences, then random traffic against a tick scoreboard model.
module tb_timer_tick_scheduler;

    localparam logic [22:0] LOAD = 23'h4C4B3F;
    localparam int          CW   = 4;

    logic          clk = 1'b0;
    logic          rst, en, rdy, tmo, irq_force;
    logic [2:0]    addr;
    logic          cs, wn;
    logic [15:0]   wd, rdata;
    logic          tmr_irq;
    logic          vld, busy;
    logic [CW-1:0] seq, ovr;
    logic [22:0]   lat;

    // timer peripheral model state
    logic          m_to, m_ito;
    logic [22:0]   m_snap, counter;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    timer_tick_scheduler #(.LOAD_VALUE(LOAD), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst), .enable(en),
        .tmr_address(addr), .tmr_chipselect(cs), .tmr_write_n(wn),
        .tmr_writedata(wd), .tmr_readdata(rdata), .tmr_irq(tmr_irq),
        .tick_valid(vld), .tick_ready(rdy), .tick_seq(seq),
        .tick_latency(lat), .overrun_count(ovr), .busy(busy)
    );

    assign tmr_irq = (m_to & m_ito) | irq_force;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_to   <= 1'b0;
            m_ito  <= 1'b0;
            m_snap <= '0;
            rdata  <= '0;
        end else begin
            case (addr)
                3'd4:    rdata <= m_snap[15:0];
                3'd5:    rdata <= {9'h1A5, m_snap[22:16]};
                default: rdata <= 16'hBEEF;
            endcase
            if (cs && !wn) begin
                case (addr)
                    3'd0:    m_to   <= 1'b0;
                    3'd1:    m_ito  <= wd[0];
                    3'd4:    m_snap <= counter;
                    default: ;
                endcase
            end
            if (tmo) m_to <= 1'b1;
        end
    end

    typedef struct {
        logic rst, en, tmo;
        logic cs, wn;
        logic [2:0] a;
        logic [15:0] wd;
        logic b, v;
        logic [CW-1:0] s;
        logic [22:0] l;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic r, input logic e, input logic t, input logic c,
                                input logic w, input logic [2:0] a, input logic [15:0] d,
                                input logic b, input logic v, input logic [CW-1:0] s,
                                input logic [22:0] l);
        vec_t x;
        x.rst = r; x.en = e; x.tmo = t; x.cs = c; x.wn = w; x.a = a; x.wd = d;
        x.b = b; x.v = v; x.s = s; x.l = l;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_bus(input logic [2:0] a, input logic w, input string nm);
        int n = 0;
        while (!(cs === 1'b1 && wn === w && addr === a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (n >= 50) begin
            miss++;
            $display("FAIL %s: got no access within 50 cycles expected access addr %0d write_n %0d",
                     nm, a, w);
        end
    endtask

    task automatic pulse_tmo();
        @(negedge clk); tmo = 1'b1;
        @(negedge clk); tmo = 1'b0;
    endtask

    task automatic service(input logic [22:0] cval, input string nm);
        counter = cval;
        pulse_tmo();
        wait_bus(3'd4, 1'b1, nm);
        repeat (4) @(negedge clk);
    endtask

    // scoreboard model for the random phase
    logic          mv;
    logic [CW-1:0] ms, mo;
    logic [22:0]   ml, psnap;
    int            cd;
    logic          emit_now;
    int            acts;

    initial begin
        rst = 1'b1; en = 1'b0; rdy = 1'b0; tmo = 1'b0; irq_force = 1'b0;
        counter = 23'h000100;

        tbl[0]  = mk(1, 1, 0, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 23'h0);
        tbl[1]  = mk(0, 1, 0, 1, 0, 3'd1, 16'h0001, 1, 0, 0, 23'h0);
        tbl[2]  = mk(0, 1, 0, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 23'h0);
        tbl[3]  = mk(0, 1, 1, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 23'h0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 3'd0, 16'h0000, 1, 0, 0, 23'h0);
        tbl[5]  = mk(0, 1, 0, 1, 0, 3'd4, 16'h0000, 1, 0, 0, 23'h0);
        tbl[6]  = mk(0, 1, 0, 1, 1, 3'd4, 16'h0000, 1, 0, 0, 23'h0);
        tbl[7]  = mk(0, 1, 0, 1, 1, 3'd5, 16'h0000, 1, 0, 0, 23'h0);
        tbl[8]  = mk(0, 1, 0, 0, 1, 3'd0, 16'h0000, 1, 0, 0, 23'h0);
        tbl[9]  = mk(0, 1, 0, 0, 1, 3'd0, 16'h0000, 1, 0, 0, 23'h0);
        tbl[10] = mk(0, 1, 0, 0, 1, 3'd0, 16'h0000, 0, 1, 1, 23'h4C4A3F);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; tmo = tbl[i].tmo;
            @(posedge clk);
            #1;
            chk($sformatf("table[%0d]", i),
                96'({cs, wn, addr, wd, busy, vld, seq, lat, ovr}),
                96'({tbl[i].cs, tbl[i].wn, tbl[i].a, tbl[i].wd, tbl[i].b, tbl[i].v,
                     tbl[i].s, tbl[i].l, CW'(0)}));
        end
        tmo = 1'b0;
        @(negedge clk);

        // overruns while the consumer stalls
        service(23'h123456, "ovr_tick2");
        chk("ovr_tick2", 96'({vld, seq, lat, ovr}), 96'({1'b1, CW'(2), 23'h3A16E9, CW'(1)}));
        service(23'h7FFFFF, "ovr_tick3");
        chk("ovr_tick3", 96'({vld, seq, lat, ovr}), 96'({1'b1, CW'(3), 23'h4C4B40, CW'(2)}));
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("ready_drop", 96'({vld, seq}), 96'({1'b0, CW'(3)}));

        // second timeout lands during RDH
        rdy = 1'b1;
        counter = 23'h000010;
        pulse_tmo();
        wait_bus(3'd5, 1'b1, "rdh_seen");
        tmo = 1'b1;
        @(negedge clk);
        tmo = 1'b0;
        repeat (3) @(negedge clk);
        chk("back_to_back_clr", 96'({cs, wn, addr}), 96'({1'b1, 1'b0, 3'd0}));
        wait_bus(3'd4, 1'b1, "second_rdl");
        repeat (4) @(negedge clk);
        chk("back_to_back_tick", 96'({vld, seq, lat, ovr}), 96'({1'b1, CW'(5), 23'h4C4B2F, CW'(2)}));
        rdy = 1'b0;

        // enable drops at RDL
        counter = 23'h000100;
        pulse_tmo();
        wait_bus(3'd4, 1'b1, "rdl_seen");
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("dis_write", 96'({cs, wn, addr, wd, seq, ovr}),
            96'({1'b1, 1'b0, 3'd1, 16'h0000, CW'(6), CW'(3)}));
        @(negedge clk);
        chk("off_idle", 96'({cs, busy}), 96'({1'b0, 1'b0}));
        irq_force = 1'b1;
        acts = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cs || busy) acts++;
        end
        irq_force = 1'b0;
        chk("off_ignores_irq", 96'(acts), 96'(0));

        // reset asserted in SNAP
        en = 1'b1;
        wait_bus(3'd1, 1'b0, "reenable");
        @(negedge clk);
        pulse_tmo();
        wait_bus(3'd4, 1'b0, "snap_seen");
        #1 rst = 1'b1;
        #1;
        chk("reset_in_snap", 96'({cs, wn, busy, vld, seq, ovr}),
            96'({1'b0, 1'b1, 1'b0, 1'b0, CW'(0), CW'(0)}));
        @(negedge clk);
        rst = 1'b0;

        // random traffic against the scoreboard
        mv = 1'b0; ms = '0; mo = '0; ml = '0; psnap = '0; cd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("random", 96'({vld, seq, lat, ovr}), 96'({mv, ms, ml, mo}));
            if ($urandom_range(0, 299) == 0) en = ~en;
            if (c < 1500) rdy = ($urandom_range(0, 9) == 0);
            else          rdy = ($urandom_range(0, 1) == 0);
            tmo     = ($urandom_range(0, 29) == 0);
            counter = 23'($urandom);
            emit_now = (cd == 1);
            if (cd > 0) cd--;
            if (cs && !wn && addr == 3'd4) begin
                cd    = 4;
                psnap = counter;
            end
            if (emit_now) begin
                if (mv && !rdy && mo != '1) mo++;
                mv = 1'b1;
                ms++;
                ml = LOAD - psnap;
            end else if (mv && rdy) begin
                mv = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
